// File: rtl/rtc_pkg.sv
// Purpose : shared constants for the RTC alarm scheduler (register map, FSM encoding, slot limit).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package rtc_pkg;

    // The 4-bit register map leaves room for at most four alarm slots.
    localparam int RTC_MAX_ALARMS = 4;

    // Register map (word addresses on the 4-bit register select)
    localparam logic [3:0] RTC_A_ALARM0  = 4'd0;   // 0..3  ALARM[i]
    localparam logic [3:0] RTC_A_PERIOD0 = 4'd4;   // 4..7  PERIOD[i]
    localparam logic [3:0] RTC_A_ENABLE  = 4'd8;
    localparam logic [3:0] RTC_A_PENDING = 4'd9;
    localparam logic [3:0] RTC_A_IRQMASK = 4'd10;

    // Scan sequencer states
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/rtc_alarm_sched.sv
// Purpose : alarm scheduler for the RTC seconds counter; NUM_ALARMS one-shot/periodic slots
//           scanned by one shared 32-bit comparator each time seconds_in changes.
// Latency : change at T -> slot k compared at T+1+k, PENDING at T+2+k, irq at T+3+k.
// Backpressure: none; bus writes always accepted, a change during a scan queues one rescan.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   seconds_in current RTC seconds value (same clock domain)
//   wr_en      single-cycle bus write strobe
//   addr       register select
//   data_in    bus write data
//   rd_data    combinational read data for addr
//   irq        registered level interrupt = |(pending & irq_mask)
module rtc_alarm_sched
    import rtc_pkg::*;
#(
    parameter int NUM_ALARMS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seconds_in,
    input  logic        wr_en,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] rd_data,
    output logic        irq
);

    // Bits of the slot-wide registers that correspond to implemented slots.
    localparam logic [3:0] SLOT_MASK = 4'((1 << NUM_ALARMS) - 1);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_ALARMS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] alarm_q  [RTC_MAX_ALARMS];
    logic [31:0] period_q [RTC_MAX_ALARMS];
    logic [3:0]  enable_q;
    logic [3:0]  pending_q;
    logic [3:0]  irq_mask_q;
    logic [31:0] seconds_q;
    logic        irq_q;

    scan_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        rescan_q, rescan_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       slot_ok;
    logic       wr_alarm, wr_period, wr_enable, wr_pending, wr_mask;
    logic [3:0] w1c_bits;

    assign slot_ok    = SLOT_MASK[addr[1:0]];
    assign wr_alarm   = wr_en && (addr[3:2] == RTC_A_ALARM0[3:2])  && slot_ok;
    assign wr_period  = wr_en && (addr[3:2] == RTC_A_PERIOD0[3:2]) && slot_ok;
    assign wr_enable  = wr_en && (addr == RTC_A_ENABLE);
    assign wr_pending = wr_en && (addr == RTC_A_PENDING);
    assign wr_mask    = wr_en && (addr == RTC_A_IRQMASK);
    assign w1c_bits   = wr_pending ? (data_in[3:0] & SLOT_MASK) : 4'b0000;

    // ------------------------------------------------------------------
    // Shared comparator / adder on the slot under evaluation
    // ------------------------------------------------------------------
    logic        chg;
    logic        scanning;
    logic [31:0] cur_alarm, cur_period, next_alarm;
    logic        collide;
    logic        fire;
    logic [3:0]  fire_vec;

    // Also catches software writes to the RTC, not just ticks.
    assign chg        = (seconds_in != seconds_q);
    assign scanning   = (state_q == S_SCAN);
    assign cur_alarm  = alarm_q[idx_q];
    assign cur_period = period_q[idx_q];
    assign next_alarm = cur_alarm + cur_period;   // wraps mod 2^32

    // A write to the evaluated slot's configuration takes priority and
    // suppresses that slot's fire for this cycle. ENABLE covers every slot.
    assign collide  = ((wr_alarm || wr_period) && (addr[1:0] == idx_q)) || wr_enable;
    // Exact equality only: a time jump over an alarm value never fires it.
    assign fire     = scanning && enable_q[idx_q] && (seconds_in == cur_alarm) && !collide;
    assign fire_vec = fire ? (4'b0001 << idx_q) : 4'b0000;

    // ------------------------------------------------------------------
    // Register file, pending and irq
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RTC_MAX_ALARMS; i++) begin
                alarm_q[i]  <= '0;
                period_q[i] <= '0;
            end
            enable_q   <= '0;
            pending_q  <= '0;
            irq_mask_q <= '0;
            seconds_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            seconds_q <= seconds_in;
            irq_q     <= |(pending_q & irq_mask_q);

            for (int i = 0; i < RTC_MAX_ALARMS; i++) begin
                if (wr_alarm && (addr[1:0] == 2'(i))) begin
                    alarm_q[i] <= data_in;
                end else if (fire && (idx_q == 2'(i)) && (cur_period != 32'd0)) begin
                    alarm_q[i] <= next_alarm;
                end
                if (wr_period && (addr[1:0] == 2'(i))) begin
                    period_q[i] <= data_in;
                end
            end

            // One-shot slots disarm themselves on fire.
            if (wr_enable) begin
                enable_q <= data_in[3:0] & SLOT_MASK;
            end else if (fire && (cur_period == 32'd0)) begin
                enable_q <= enable_q & ~fire_vec;
            end

            // Set beats a simultaneous write-1-to-clear of the same bit.
            pending_q <= (pending_q & ~w1c_bits) | fire_vec;

            if (wr_mask) begin
                irq_mask_q <= data_in[3:0] & SLOT_MASK;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rescan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rescan_q <= rescan_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rescan_d = rescan_q;
        unique case (state_q)
            S_IDLE: begin
                if (chg) begin
                    state_d  = S_SCAN;
                    idx_d    = 2'd0;
                    rescan_d = 1'b0;
                end
            end
            S_SCAN: begin
                if (chg) begin
                    rescan_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    // A change on the final slot cycle counts too, so no change is lost.
                    if (rescan_q || chg) begin
                        idx_d    = 2'd0;
                        rescan_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (addr[3:2] == RTC_A_ALARM0[3:2]) begin
            if (slot_ok) rd_data = alarm_q[addr[1:0]];
        end else if (addr[3:2] == RTC_A_PERIOD0[3:2]) begin
            if (slot_ok) rd_data = period_q[addr[1:0]];
        end else if (addr == RTC_A_ENABLE) begin
            rd_data = {28'd0, enable_q};
        end else if (addr == RTC_A_PENDING) begin
            rd_data = {28'd0, pending_q};
        end else if (addr == RTC_A_IRQMASK) begin
            rd_data = {28'd0, irq_mask_q};
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_rtc_alarm_sched.sv
// Purpose : directed self-checking bench for rtc_alarm_sched (table rows + timed corner sequences).
// Latency : checks the T+2 pending / T+3 irq timing and back-to-back rescans.
// Backpressure: n/a.
module tb_rtc_alarm_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seconds_in = 32'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] rd_data;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_alarm_sched #(.NUM_ALARMS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seconds_in (seconds_in),
        .wr_en      (wr_en),
        .addr       (addr),
        .data_in    (data_in),
        .rd_data    (rd_data),
        .irq        (irq)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] secs;
        logic [1:0]  chk;      // bit0: rd_data, bit1: irq
        logic [31:0] exp_rd;
        logic        exp_irq;
        int          idle;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] tbl_secs;

    function automatic void add(input logic we, input logic [3:0] a, input logic [31:0] d,
                                input logic [1:0] chk, input logic [31:0] er, input logic ei,
                                input int idle, input string name);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.secs = tbl_secs; v.chk = chk;
        v.exp_rd = er; v.exp_irq = ei; v.idle = idle; v.name = name;
        tbl.push_back(v);
    endfunction

    function automatic void W(input logic [3:0] a, input logic [31:0] d);
        add(1'b1, a, d, 2'b00, 32'd0, 1'b0, 0, "wr");
    endfunction
    function automatic void R(input string name, input logic [3:0] a, input logic [31:0] e);
        add(1'b0, a, 32'd0, 2'b01, e, 1'b0, 0, name);
    endfunction
    function automatic void RI(input string name, input logic [3:0] a, input logic [31:0] e, input logic ei);
        add(1'b0, a, 32'd0, 2'b11, e, ei, 0, name);
    endfunction
    function automatic void S(input logic [31:0] s);
        tbl_secs = s;
        add(1'b0, 4'd0, 32'd0, 2'b00, 32'd0, 1'b0, 6, "secs");
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        #1;
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_secs(input logic [31:0] s);
        @(negedge clk);
        seconds_in = s;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        // ---------------- table contents ----------------
        tbl_secs = 32'd100;
        // periodic slot 1
        W(4'd9, 32'hF); W(4'd10, 32'd2); W(4'd1, 32'd10); W(4'd5, 32'd5); W(4'd8, 32'd2);
        RI("t2_alarm1_init", 4'd1, 32'd10, 1'b0);
        R("t2_period1", 4'd5, 32'd5);
        R("t2_enable", 4'd8, 32'd2);
        S(32'd10);
        RI("t2_pend_fire1", 4'd9, 32'd2, 1'b1);
        R("t2_alarm1_15", 4'd1, 32'd15);
        W(4'd9, 32'd2);
        RI("t2_pend_w1c", 4'd9, 32'd0, 1'b0);
        S(32'd15);
        RI("t2_pend_fire2", 4'd9, 32'd2, 1'b1);
        R("t2_alarm1_20", 4'd1, 32'd20);
        R("t2_enable_kept", 4'd8, 32'd2);
        // periodic wrap of the alarm value
        W(4'd9, 32'd2); W(4'd6, 32'd3); W(4'd2, 32'hFFFF_FFFE); W(4'd8, 32'd4); W(4'd10, 32'd4);
        S(32'hFFFF_FFFE);
        R("t3_alarm2_wrap", 4'd2, 32'h0000_0001);
        RI("t3_pend", 4'd9, 32'd4, 1'b1);
        // seconds wrap to 0 fires an ALARM=0 one-shot
        W(4'd9, 32'd4); W(4'd6, 32'd0); W(4'd2, 32'd0);
        S(32'hFFFF_FFFF);
        R("t3_pend_none", 4'd9, 32'd0);
        S(32'd0);
        RI("t3_pend_zero", 4'd9, 32'd4, 1'b1);
        R("t3_enable_off", 4'd8, 32'd0);
        // register map edges
        W(4'd11, 32'hDEAD_BEEF);
        R("map_addr11", 4'd11, 32'd0);
        R("map_addr15", 4'd15, 32'd0);
        W(4'd10, 32'hFFFF_FFFF);
        R("map_mask_bits", 4'd10, 32'hF);
        W(4'd8, 32'hFFFF_FFF0);
        R("map_enable_bits", 4'd8, 32'd0);
        R("map_pend_kept", 4'd9, 32'd4);
        W(4'd3, 32'h1234_5678);
        R("map_alarm3", 4'd3, 32'h1234_5678);
        W(4'd10, 32'd0);
        RI("map_mask_clr", 4'd9, 32'd4, 1'b0);
        W(4'd9, 32'hF);
        R("map_pend_clr", 4'd9, 32'd0);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) rd_chk("rst_reads", 4'(a), 32'd0);
        irq_chk("rst_irq", 1'b0);

        // ---------------- one-shot timing ----------------
        wr(4'd10, 32'd1); wr(4'd0, 32'd100); wr(4'd4, 32'd0); wr(4'd8, 32'd1);
        set_secs(32'd99);
        @(negedge clk); seconds_in = 32'd100;            // cycle T
        rd_chk("t1_pend_T", 4'd9, 32'd0);
        @(negedge clk); rd_chk("t1_pend_T1", 4'd9, 32'd0);
        @(negedge clk); rd_chk("t1_pend_T2", 4'd9, 32'd1);
        irq_chk("t1_irq_T2", 1'b0);
        @(negedge clk); irq_chk("t1_irq_T3", 1'b1);
        repeat (2) @(negedge clk);
        rd_chk("t1_enable_off", 4'd8, 32'd0);

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            @(negedge clk);
            seconds_in = tbl[i].secs;
            addr       = tbl[i].addr;
            data_in    = tbl[i].wdata;
            wr_en      = tbl[i].we;
            #1;
            if (tbl[i].chk[0]) check(tbl[i].name, rd_data, tbl[i].exp_rd);
            if (tbl[i].chk[1]) check({tbl[i].name, "_irq"}, {31'd0, irq}, {31'd0, tbl[i].exp_irq});
            @(negedge clk);
            wr_en = 1'b0;
            repeat (tbl[i].idle) @(negedge clk);
        end

        // ---------------- back-to-back rescan ----------------
        wr(4'd0, 32'd200); wr(4'd4, 32'd1); wr(4'd8, 32'd1);
        set_secs(32'd199);
        @(negedge clk); seconds_in = 32'd200;            // T
        rd_chk("t4_alarm0_T", 4'd0, 32'd200);
        @(negedge clk);                                  // T+1: slot 0 fires
        @(negedge clk); seconds_in = 32'd201;            // T+2
        rd_chk("t4_alarm0_T2", 4'd0, 32'd201);
        repeat (3) @(negedge clk);                       // T+5: rescan slot 0
        rd_chk("t4_alarm0_T5", 4'd0, 32'd201);
        @(negedge clk); rd_chk("t4_alarm0_T6", 4'd0, 32'd202);
        repeat (4) @(negedge clk);
        rd_chk("t4_pend", 4'd9, 32'd1);

        // ---------------- write collision ----------------
        wr(4'd9, 32'hF); wr(4'd4, 32'd0); wr(4'd0, 32'd300);
        set_secs(32'd299);
        @(negedge clk); seconds_in = 32'd300;            // T
        @(negedge clk);                                  // T+1: slot 0 would match
        wr_en = 1'b1; addr = 4'd0; data_in = 32'd500;
        @(negedge clk); wr_en = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk("t5_alarm0_new", 4'd0, 32'd500);
        rd_chk("t5_pend_none", 4'd9, 32'd0);
        rd_chk("t5_enable_kept", 4'd8, 32'd1);

        // ---------------- set beats W1C ----------------
        wr(4'd1, 32'd400); wr(4'd8, 32'd2);
        set_secs(32'd399);
        @(negedge clk); seconds_in = 32'd400;            // T
        @(negedge clk);                                  // T+1
        @(negedge clk);                                  // T+2: slot 1 fires
        wr_en = 1'b1; addr = 4'd9; data_in = 32'd2;
        @(negedge clk); wr_en = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("t5_pend_set_wins", 4'd9, 32'd2);
        rd_chk("t5_alarm1_405", 4'd1, 32'd405);

        // ---------------- reset mid-scan ----------------
        wr(4'd10, 32'd2);
        repeat (2) @(negedge clk);
        irq_chk("t6_irq_before", 1'b1);
        @(negedge clk); seconds_in = 32'd405;            // T
        @(negedge clk); rst_n = 1'b0;                    // T+1
        @(negedge clk); rst_n = 1'b1;                    // T+2
        for (int a = 0; a < 11; a++) rd_chk("t6_reads_zero", 4'(a), 32'd0);
        irq_chk("t6_irq_zero", 1'b0);
        repeat (6) @(negedge clk);
        wr(4'd0, 32'd55); wr(4'd8, 32'd1); wr(4'd10, 32'd1);
        set_secs(32'd50);
        set_secs(32'd60);
        rd_chk("t6_jump_no_fire", 4'd9, 32'd0);
        rd_chk("t6_enable_kept", 4'd8, 32'd1);
        rd_chk("t6_alarm0", 4'd0, 32'd55);
        irq_chk("t6_irq_none", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
